lane_receiver: RTL
==================

# lane_receiver

Receive-side lane block for the Aurora 8B/10B path, sitting after the per-lane 8b/10b decoder. It tracks lane initialisation from comma alignment through verification to lane-up. Once the lane is up, it strips idle/clock-compensation characters, delimits frames on /SCP/ and /ECP/, and delivers payload bytes as a valid/last byte stream. It is the counterpart of the transmit-side lane controller and idle generator, and handles one lane; multi-lane bonding instantiates one per lane.

## Interface
Parameters:
- VERIFY_COUNT, 64, consecutive /V/ characters required to declare the lane up.
- ERR_LIMIT, 4, consecutive decode errors in READY that force the lane back to alignment.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous, active-low.
- ctrl_in  in  1  decoder K-flag for the current character.
- data_in  in  ENCODER_DATA_IN_SIZE (8)  decoded character.
- decode_err  in  1  disparity or code-violation flag for the current character.
- lane_up  out  1  lane verified and in READY.
- rx_data  out  8  payload byte.
- rx_valid  out  1  rx_data is valid this cycle.
- rx_last  out  1  with rx_valid, marks the final byte of a frame.
- frame_err  out  1  one-cycle pulse on a framing violation.
- soft_err  out  1  one-cycle pulse per decode error while in READY.
- got_a  out  1  one-cycle pulse on /A/ in READY, for future channel bonding.
- rx_char  out  rx_char_e  registered classification of the last character.

## Operation
- Character codes, valid only with ctrl_in=1:
  - /K/ = K28.5 (0xBC), /R/ = K28.0 (0x1C), /A/ = K28.3 (0x7C), /V/ = K28.7 (0xFC).
  - SCP = K28.2 (0x5C) then K27.7 (0xFB).
  - ECP = K29.7 (0xFD) then K30.7 (0xFE).
- Any other K code is "unexpected control".
- Lane FSM, reset state ALIGN:
  - ALIGN: stays until /K/ is received without decode_err, then goes to VERIFY with the verify count cleared.
  - VERIFY:
    - /V/ increments the count.
    - /K/, /R/ and /A/ leave the count unchanged.
    - A data character or unexpected control clears the count.
    - decode_err goes to ALIGN.
    - When the count reaches VERIFY_COUNT, go to READY.
  - READY:
    - lane_up=1.
    - decode_err pulses soft_err and increments the consecutive-error count; any clean character clears that count.
    - When the count reaches ERR_LIMIT, go to ALIGN.
- Frame FSM, active only in READY; reset state IDLE:
  - IDLE: 0x5C goes to SCP1. Everything else is ignored.
  - SCP1: 0xFB goes to FRAME. Anything else returns to IDLE and pulses frame_err.
  - FRAME:
    - A data character is buffered in a one-byte hold register. If the hold register is already full, its old byte is emitted with rx_last=0.
    - /K/, /R/, /A/ and /V/ are dropped.
    - 0xFD goes to ECP1.
    - 0x5C aborts the frame: the hold byte is discarded, frame_err pulses, and the FSM goes to SCP1.
    - Other unexpected control aborts the frame: the hold byte is discarded, frame_err pulses, and the FSM goes to IDLE.
  - ECP1:
    - 0xFE emits the hold byte with rx_last=1 and goes to IDLE.
    - If the hold register is empty (empty frame), nothing is emitted and there is no error.
    - Anything else discards the hold byte, pulses frame_err, and goes to IDLE.
- A character with decode_err is never treated as data or as a delimiter. In FRAME or ECP1 it aborts the frame, exactly as unexpected control does.
- Leaving READY while the frame FSM is not IDLE: discard the hold byte, pulse frame_err once, and force the frame FSM to IDLE.

## Timing
- All outputs are registered.
- Reset values: lane_up=0, rx_valid=0, rx_last=0, rx_data=0, frame_err=0, soft_err=0, got_a=0, rx_char=RX_NONE. Both FSMs are in their reset states, and all counters and the hold register are cleared.
- rx_char, got_a and soft_err: 1 cycle after the character is sampled.
- lane_up rises 1 cycle after the VERIFY_COUNT-th /V/ is sampled. It falls 1 cycle after the ERR_LIMIT-th consecutive error.
- Payload byte latency:
  - A byte is emitted 1 cycle after the next data character is sampled, or 1 cycle after 0xFE is sampled.
  - Minimum latency is 2 cycles.
  - rx_valid has no backpressure.
- A new frame may start on the cycle immediately after 0xFE.
- rst_n low mid-frame: the hold byte is lost and frame_err is not pulsed.

## Structure
- aurora_pkg gains:
  - constants K_CHAR, R_CHAR, A_CHAR, V_CHAR, SCP1_CHAR, SCP2_CHAR, ECP1_CHAR, ECP2_CHAR;
  - enum rx_char_e {RX_NONE, RX_DATA, RX_K, RX_R, RX_A, RX_V, RX_SCP1, RX_SCP2, RX_ECP1, RX_ECP2, RX_BADCTRL, RX_ERR};
  - enums lane_rx_state_e and frame_rx_state_e.
- Sub-module rx_char_classifier: purely combinational, maps {ctrl_in, data_in, decode_err} to rx_char_e.
- The lane FSM, frame FSM and counters live in lane_receiver.

## Test plan
- Bring-up: 1 /K/, then 64 /V/ with VERIFY_COUNT=64 -> lane_up=1 exactly 1 cycle after the 64th /V/. A data byte after 63 /V/ -> count restarts and 64 more /V/ are needed.
- Frame: SCP, data 0x11 0x22 0x33, ECP -> rx_valid for 3 cycles with data 11,22,33 and rx_last only on 0x33, which appears 1 cycle after 0xFE.
- Idles inside a frame: SCP, 0xAA, /R/, /A/, 0xBB, ECP -> output AA then BB(last), and got_a pulses once.
- Errors:
  - SCP, 0x55, then 0xBC with decode_err -> frame_err pulse, soft_err pulse, no output.
  - 4 consecutive decode_err -> lane_up=0 and state ALIGN.
- Boundaries:
  - Empty frame SCP/ECP -> no output and no frame_err.
  - SCP immediately after 0xFE -> frame accepted.
  - rst_n low mid-frame -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/aurora_pkg.sv
// ==========================================================================
// aurora_pkg: shared character codes and state types for the Aurora lane.
// Rev 1.0
// ==========================================================================
`default_nettype none

package aurora_pkg;

  localparam int ENCODER_DATA_IN_SIZE = 8;

  localparam logic [7:0] K_CHAR    = 8'hBC;
  localparam logic [7:0] R_CHAR    = 8'h1C;
  localparam logic [7:0] A_CHAR    = 8'h7C;
  localparam logic [7:0] V_CHAR    = 8'hFC;
  localparam logic [7:0] SCP1_CHAR = 8'h5C;
  localparam logic [7:0] SCP2_CHAR = 8'hFB;
  localparam logic [7:0] ECP1_CHAR = 8'hFD;
  localparam logic [7:0] ECP2_CHAR = 8'hFE;

  typedef enum logic [3:0] {
    RX_NONE, RX_DATA, RX_K, RX_R, RX_A, RX_V,
    RX_SCP1, RX_SCP2, RX_ECP1, RX_ECP2, RX_BADCTRL, RX_ERR
  } rx_char_e;

  typedef enum logic [1:0] {
    LANE_ALIGN, LANE_VERIFY, LANE_READY
  } lane_rx_state_e;

  typedef enum logic [1:0] {
    FR_IDLE, FR_SCP1, FR_FRAME, FR_ECP1
  } frame_rx_state_e;

endpackage

`default_nettype wire

// File: rtl/rx_char_classifier.sv
// ==========================================================================
// rx_char_classifier: maps a decoded character to its rx_char_e class.
// Rev 1.0
// ==========================================================================
`default_nettype none

module rx_char_classifier
  import aurora_pkg::*;
(
  input  logic                            ctrl_in,
  input  logic [ENCODER_DATA_IN_SIZE-1:0] data_in,
  input  logic                            decode_err,
  output rx_char_e                        char_class
);

  // A decode error overrides everything so a corrupted delimiter is never acted on.
  always_comb begin
    char_class = RX_DATA;
    if (decode_err) begin
      char_class = RX_ERR;
    end else if (ctrl_in) begin
      case (data_in)
        K_CHAR:    char_class = RX_K;
        R_CHAR:    char_class = RX_R;
        A_CHAR:    char_class = RX_A;
        V_CHAR:    char_class = RX_V;
        SCP1_CHAR: char_class = RX_SCP1;
        SCP2_CHAR: char_class = RX_SCP2;
        ECP1_CHAR: char_class = RX_ECP1;
        ECP2_CHAR: char_class = RX_ECP2;
        default:   char_class = RX_BADCTRL;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/lane_receiver.sv
// ==========================================================================
// lane_receiver: Aurora 8B/10B receive lane bring-up and frame delimiting.
// Rev 1.0
// ==========================================================================
`default_nettype none

module lane_receiver
  import aurora_pkg::*;
#(
  parameter int VERIFY_COUNT = 64,
  parameter int ERR_LIMIT    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ctrl_in,
  input  logic [ENCODER_DATA_IN_SIZE-1:0] data_in,
  input  logic                            decode_err,
  output logic                            lane_up,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  output logic                            rx_last,
  output logic                            frame_err,
  output logic                            soft_err,
  output logic                            got_a,
  output rx_char_e                        rx_char
);

  localparam int VCNT_W = $clog2(VERIFY_COUNT + 1);
  localparam int ECNT_W = $clog2(ERR_LIMIT + 1);

  rx_char_e        cls;
  lane_rx_state_e  lane_state, lane_next;
  frame_rx_state_e frame_state, frame_next;
  logic [VCNT_W-1:0] vcnt, vcnt_next;
  logic [ECNT_W-1:0] ecnt, ecnt_next;
  logic [7:0] hold, hold_next;
  logic       hold_full, hold_full_next;
  logic [7:0] data_next;
  logic       valid_next, last_next, ferr_next, serr_next, gota_next;

  rx_char_classifier u_classifier (
    .ctrl_in    (ctrl_in),
    .data_in    (data_in),
    .decode_err (decode_err),
    .char_class (cls)
  );

  // Lane initialisation and error-run tracking.
  always_comb begin
    lane_next = lane_state;
    vcnt_next = vcnt;
    ecnt_next = ecnt;
    serr_next = 1'b0;
    gota_next = 1'b0;
    case (lane_state)
      LANE_ALIGN: begin
        if (cls == RX_K) begin
          lane_next = LANE_VERIFY;
          vcnt_next = '0;
        end
      end
      LANE_VERIFY: begin
        case (cls)
          RX_ERR: lane_next = LANE_ALIGN;
          RX_V: begin
            if (vcnt == VCNT_W'(VERIFY_COUNT - 1)) begin
              lane_next = LANE_READY;
              vcnt_next = '0;
              ecnt_next = '0;
            end else begin
              vcnt_next = vcnt + 1'b1;
            end
          end
          RX_K, RX_R, RX_A: ;
          default: vcnt_next = '0;
        endcase
      end
      LANE_READY: begin
        if (cls == RX_ERR) begin
          serr_next = 1'b1;
          if (ecnt == ECNT_W'(ERR_LIMIT - 1)) begin
            lane_next = LANE_ALIGN;
            ecnt_next = '0;
          end else begin
            ecnt_next = ecnt + 1'b1;
          end
        end else begin
          ecnt_next = '0;
          gota_next = (cls == RX_A);
        end
      end
      default: lane_next = LANE_ALIGN;
    endcase
  end

  // Frame delimiting; the one-byte hold lets the final byte carry rx_last when ECP arrives.
  always_comb begin
    frame_next     = frame_state;
    hold_next      = hold;
    hold_full_next = hold_full;
    data_next      = rx_data;
    valid_next     = 1'b0;
    last_next      = 1'b0;
    ferr_next      = 1'b0;
    if (lane_state != LANE_READY) begin
      frame_next     = FR_IDLE;
      hold_full_next = 1'b0;
    end else begin
      case (frame_state)
        FR_IDLE: begin
          if (cls == RX_SCP1) frame_next = FR_SCP1;
        end
        FR_SCP1: begin
          hold_full_next = 1'b0;
          if (cls == RX_SCP2) begin
            frame_next = FR_FRAME;
          end else begin
            frame_next = FR_IDLE;
            ferr_next  = 1'b1;
          end
        end
        FR_FRAME: begin
          case (cls)
            RX_DATA: begin
              if (hold_full) begin
                valid_next = 1'b1;
                data_next  = hold;
              end
              hold_next      = data_in;
              hold_full_next = 1'b1;
            end
            RX_K, RX_R, RX_A, RX_V: ;
            RX_ECP1: frame_next = FR_ECP1;
            RX_SCP1: begin
              frame_next     = FR_SCP1;
              hold_full_next = 1'b0;
              ferr_next      = 1'b1;
            end
            default: begin
              frame_next     = FR_IDLE;
              hold_full_next = 1'b0;
              ferr_next      = 1'b1;
            end
          endcase
        end
        FR_ECP1: begin
          frame_next     = FR_IDLE;
          hold_full_next = 1'b0;
          if (cls == RX_ECP2) begin
            if (hold_full) begin
              valid_next = 1'b1;
              last_next  = 1'b1;
              data_next  = hold;
            end
          end else begin
            ferr_next = 1'b1;
          end
        end
        default: frame_next = FR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_state  <= LANE_ALIGN;
      frame_state <= FR_IDLE;
      vcnt        <= '0;
      ecnt        <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      lane_up     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_last     <= 1'b0;
      frame_err   <= 1'b0;
      soft_err    <= 1'b0;
      got_a       <= 1'b0;
      rx_char     <= RX_NONE;
    end else begin
      lane_state  <= lane_next;
      frame_state <= frame_next;
      vcnt        <= vcnt_next;
      ecnt        <= ecnt_next;
      hold        <= hold_next;
      hold_full   <= hold_full_next;
      lane_up     <= (lane_next == LANE_READY);
      rx_data     <= data_next;
      rx_valid    <= valid_next;
      rx_last     <= last_next;
      frame_err   <= ferr_next;
      soft_err    <= serr_next;
      got_a       <= gota_next;
      rx_char     <= cls;
    end
  end

endmodule

`default_nettype wire
